// File: rtl/cpu_run_controller.sv
// Run-control unit for the single-cycle MIPS datapath: turns debounced push-buttons
// into single-cycle instruction and memory enables, with slow/fast run and a PC breakpoint.

module RunKeyConditioner #(
   parameter int DEBOUNCE = 500000
) (
   input  logic iCLK,
   input  logic iRST,
   input  logic iKey,
   output logic oPress
);

   localparam int DW = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
   localparam logic [DW-1:0] DB_TC = DW'(DEBOUNCE - 1);

   logic          sync1_q, sync2_q;
   logic          level_q, level_d;
   logic          press_q, press_d;
   logic [DW-1:0] dbCnt_q, dbCnt_d;

   // The accepted level only moves after DEBOUNCE consecutive disagreeing samples;
   // a press is flagged on the cycle the level rises.
   always_comb begin
      dbCnt_d = '0;
      level_d = level_q;
      press_d = 1'b0;
      if (sync2_q != level_q) begin
         if (dbCnt_q == DB_TC) begin
            level_d = sync2_q;
            press_d = sync2_q;
         end else begin
            dbCnt_d = dbCnt_q + 1'b1;
         end
      end
   end

   always_ff @(posedge iCLK) begin
      if (iRST) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         level_q <= 1'b0;
         press_q <= 1'b0;
         dbCnt_q <= '0;
      end else begin
         sync1_q <= iKey;
         sync2_q <= sync1_q;
         level_q <= level_d;
         press_q <= press_d;
         dbCnt_q <= dbCnt_d;
      end
   end

   assign oPress = press_q;

endmodule

module cpu_run_controller #(
   parameter int SLOW_DIV = 10000000,
   parameter int FAST_DIV = 31,
   parameter int MEM_DIV  = 5,
   parameter int DEBOUNCE = 500000
) (
   input  logic        iCLK,
   input  logic        iRST,
   input  logic        iKeyStep,
   input  logic        iKeyRun,
   input  logic        iKeySpeed,
   input  logic        iBreakEn,
   input  logic [31:0] iBreakPC,
   input  logic [31:0] iPC,
   output logic        oCPUEn,
   output logic        oMemEn,
   output logic [1:0]  oState,
   output logic        oFast,
   output logic        oBreakHit,
   output logic [31:0] oStepCount
);

   localparam int MAX_DIV = (SLOW_DIV > FAST_DIV) ? SLOW_DIV : FAST_DIV;
   localparam int RW      = $clog2(MAX_DIV);
   localparam int MW      = (MEM_DIV > 1) ? $clog2(MEM_DIV) : 1;
   localparam logic [RW-1:0] SLOW_TC = RW'(SLOW_DIV - 1);
   localparam logic [RW-1:0] FAST_TC = RW'(FAST_DIV - 1);
   localparam logic [MW-1:0] MEM_TC  = MW'(MEM_DIV - 1);

   typedef enum logic [1:0] {
      HALT = 2'b00,
      RUN  = 2'b01,
      BRK  = 2'b10
   } runState_e;

   runState_e     state_q, state_d;
   logic [RW-1:0] rateCnt_q, rateCnt_d;
   logic [MW-1:0] memCnt_q, memCnt_d;
   logic          skip_q, skip_d;
   logic          fast_q, fast_d;
   logic          cpuEn_q, cpuEn_d;
   logic          memEn_q, memEn_d;
   logic          breakHit_q, breakHit_d;
   logic [31:0]   stepCount_q, stepCount_d;
   logic          stepPress, runPress, speedPress;
   logic          issue, rateTc, breakMatch;

   RunKeyConditioner #(.DEBOUNCE(DEBOUNCE)) uStepKey (
      .iCLK(iCLK), .iRST(iRST), .iKey(iKeyStep), .oPress(stepPress)
   );
   RunKeyConditioner #(.DEBOUNCE(DEBOUNCE)) uRunKey (
      .iCLK(iCLK), .iRST(iRST), .iKey(iKeyRun), .oPress(runPress)
   );
   RunKeyConditioner #(.DEBOUNCE(DEBOUNCE)) uSpeedKey (
      .iCLK(iCLK), .iRST(iRST), .iKey(iKeySpeed), .oPress(speedPress)
   );

   assign rateTc     = fast_q ? (rateCnt_q == FAST_TC) : (rateCnt_q == SLOW_TC);
   assign breakMatch = iBreakEn && (iPC == iBreakPC);

   always_ff @(posedge iCLK) begin
      if (iRST) begin
         state_q   <= HALT;
         rateCnt_q <= '0;
         skip_q    <= 1'b0;
         fast_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         rateCnt_q <= rateCnt_d;
         skip_q    <= skip_d;
         fast_q    <= fast_d;
      end
   end

   // Only run-mode terminal counts consult the breakpoint; the skip flag lets the
   // breakpointed instruction go through once after resuming from BRK.
   always_comb begin
      state_d   = state_q;
      rateCnt_d = '0;
      skip_d    = skip_q;
      fast_d    = speedPress ? ~fast_q : fast_q;
      issue     = 1'b0;
      case (state_q)
         HALT: begin
            if (runPress) begin
               state_d = RUN;
            end else if (stepPress) begin
               issue  = 1'b1;
               skip_d = 1'b0;
            end
         end
         RUN: begin
            if (runPress) begin
               state_d = HALT;
            end else begin
               rateCnt_d = rateTc ? '0 : rateCnt_q + 1'b1;
               if (rateTc) begin
                  if (breakMatch && !skip_q) begin
                     state_d = BRK;
                  end else begin
                     issue  = 1'b1;
                     skip_d = 1'b0;
                  end
               end
            end
         end
         BRK: begin
            if (runPress) begin
               state_d = RUN;
               skip_d  = 1'b1;
            end else if (stepPress) begin
               state_d = HALT;
               issue   = 1'b1;
               skip_d  = 1'b0;
            end
         end
         default: state_d = HALT;
      endcase
      if (speedPress) rateCnt_d = '0;
   end

   always_comb begin
      cpuEn_d     = issue;
      breakHit_d  = (state_d == BRK);
      stepCount_d = issue ? stepCount_q + 32'd1 : stepCount_q;
      memEn_d     = (memCnt_q == MEM_TC);
      memCnt_d    = (memCnt_q == MEM_TC) ? '0 : memCnt_q + 1'b1;
   end

   // Every output comes straight from a flop so the board sees clean single-cycle pulses.
   always_ff @(posedge iCLK) begin
      if (iRST) begin
         cpuEn_q     <= 1'b0;
         memEn_q     <= 1'b0;
         breakHit_q  <= 1'b0;
         stepCount_q <= '0;
         memCnt_q    <= '0;
      end else begin
         cpuEn_q     <= cpuEn_d;
         memEn_q     <= memEn_d;
         breakHit_q  <= breakHit_d;
         stepCount_q <= stepCount_d;
         memCnt_q    <= memCnt_d;
      end
   end

   assign oCPUEn     = cpuEn_q;
   assign oMemEn     = memEn_q;
   assign oState     = state_q;
   assign oFast      = fast_q;
   assign oBreakHit  = breakHit_q;
   assign oStepCount = stepCount_q;

endmodule

// File: tb/tb_cpu_run_controller.sv
// Directed bench for cpu_run_controller: key conditioning, run rates, breakpoint,
// step/run priority and mid-run reset, using a +4-per-pulse PC model.

module tb_cpu_run_controller;

   localparam int DEBOUNCE = 4;
   localparam int SLOW_DIV = 8;
   localparam int FAST_DIV = 3;
   localparam int MEM_DIV  = 5;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        keyStep = 1'b0, keyRun = 1'b0, keySpeed = 1'b0;
   logic        breakEn = 1'b0;
   logic [31:0] breakPC = 32'd0;
   logic [31:0] pc = 32'd0;
   logic        cpuEn, memEn, fast, breakHit;
   logic [1:0]  state;
   logic [31:0] stepCount;

   int testsRun = 0;
   int testsFailed = 0;
   int cyc = 0;
   int pulseLog[$];

   typedef struct {
      logic        step;
      logic        expEn;
      logic [31:0] expCount;
   } vec_t;

   vec_t vecs[35];

   always #5 clk = ~clk;

   cpu_run_controller #(
      .SLOW_DIV(SLOW_DIV), .FAST_DIV(FAST_DIV), .MEM_DIV(MEM_DIV), .DEBOUNCE(DEBOUNCE)
   ) dut (
      .iCLK(clk), .iRST(rst), .iKeyStep(keyStep), .iKeyRun(keyRun), .iKeySpeed(keySpeed),
      .iBreakEn(breakEn), .iBreakPC(breakPC), .iPC(pc),
      .oCPUEn(cpuEn), .oMemEn(memEn), .oState(state), .oFast(fast),
      .oBreakHit(breakHit), .oStepCount(stepCount)
   );

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      testsRun++;
      if (act !== exp) begin
         testsFailed++;
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end
   endtask

   // One clock: the PC model advances on the edge that ends a pulse cycle.
   task automatic tick();
      logic en;
      en = cpuEn;
      @(posedge clk);
      #1;
      if (en === 1'b1) pc = pc + 32'd4;
      cyc++;
      if (cpuEn === 1'b1) pulseLog.push_back(cyc);
   endtask

   task automatic runCycles(input int n);
      repeat (n) tick();
   endtask

   task automatic applyStimulus(input logic step, input logic run, input logic speed);
      keyStep  = step;
      keyRun   = run;
      keySpeed = speed;
   endtask

   task automatic checkPulseTrain(input string name, input int idx, input int first,
                                  input int period, input int count);
      for (int k = 0; k < count; k++) begin
         int got;
         got = (idx + k < pulseLog.size()) ? pulseLog[idx + k] : -1;
         checkOutput($sformatf("%s[%0d]", name, k), 32'(got), 32'(first + k * period));
      end
   endtask

   task automatic checkResetOutputs(input string tag);
      checkOutput({tag, " cpuEn"},     32'(cpuEn),    32'd0);
      checkOutput({tag, " memEn"},     32'(memEn),    32'd0);
      checkOutput({tag, " state"},     32'(state),    32'd0);
      checkOutput({tag, " fast"},      32'(fast),     32'd0);
      checkOutput({tag, " breakHit"},  32'(breakHit), 32'd0);
      checkOutput({tag, " stepCount"}, stepCount,     32'd0);
   endtask

   initial begin
      int c0, b0, r0, s0, q0, rr;

      // 3-cycle glitch, gap, 20-cycle hold from index 7, release from 27.
      for (int j = 0; j < 35; j++) begin
         vecs[j].step     = (j < 3) || (j >= 7 && j < 27);
         vecs[j].expEn    = (j == 13);
         vecs[j].expCount = (j >= 13) ? 32'd1 : 32'd0;
      end

      applyStimulus(1'b0, 1'b0, 1'b0);
      rst = 1'b1;
      runCycles(3);
      checkResetOutputs("reset");

      rst = 1'b0;
      for (int i = 1; i <= 40; i++) begin
         tick();
         checkOutput($sformatf("idle cpuEn c%0d", i), 32'(cpuEn), 32'd0);
         checkOutput($sformatf("idle memEn c%0d", i), 32'(memEn), 32'(i % 5 == 0));
      end
      checkOutput("idle state", 32'(state), 32'd0);
      checkOutput("idle stepCount", stepCount, 32'd0);

      for (int j = 0; j < 35; j++) begin
         applyStimulus(vecs[j].step, 1'b0, 1'b0);
         tick();
         checkOutput($sformatf("step vec%0d cpuEn", j), 32'(cpuEn), 32'(vecs[j].expEn));
         checkOutput($sformatf("step vec%0d count", j), stepCount, vecs[j].expCount);
         checkOutput($sformatf("step vec%0d state", j), 32'(state), 32'd0);
      end

      // Slow run, then switch to fast after three pulses.
      pulseLog.delete();
      c0 = cyc;
      applyStimulus(1'b0, 1'b1, 1'b0);
      runCycles(10);
      applyStimulus(1'b0, 1'b0, 1'b0);
      runCycles(18);
      applyStimulus(1'b0, 1'b0, 1'b1);
      runCycles(6);
      checkOutput("fast before toggle", 32'(fast), 32'd0);
      runCycles(1);
      checkOutput("fast after toggle", 32'(fast), 32'd1);
      runCycles(3);
      applyStimulus(1'b0, 1'b0, 1'b0);
      runCycles(6);
      checkOutput("run pulse count", 32'(pulseLog.size()), 32'd6);
      checkPulseTrain("slow pulse", 0, c0 + 15, 8, 3);
      checkPulseTrain("fast pulse", 3, c0 + 38, 3, 3);
      checkOutput("run stepCount", stepCount, 32'd7);
      checkOutput("run state", 32'(state), 32'd1);

      runCycles(1);
      applyStimulus(1'b0, 1'b1, 1'b0);
      runCycles(10);
      applyStimulus(1'b0, 1'b0, 1'b0);
      runCycles(10);
      checkOutput("halt state", 32'(state), 32'd0);
      checkOutput("halt pulse count", 32'(pulseLog.size()), 32'd8);
      checkOutput("halt stepCount", stepCount, 32'd9);

      // Fast run into a breakpoint at 0x00400010.
      pc = 32'h0040_0000;
      breakEn = 1'b1;
      breakPC = 32'h0040_0010;
      pulseLog.delete();
      b0 = cyc;
      applyStimulus(1'b0, 1'b1, 1'b0);
      runCycles(10);
      applyStimulus(1'b0, 1'b0, 1'b0);
      runCycles(11);
      checkOutput("pre-break state", 32'(state), 32'd1);
      runCycles(1);
      checkOutput("break state", 32'(state), 32'd2);
      checkOutput("break hit", 32'(breakHit), 32'd1);
      checkOutput("break pc", pc, 32'h0040_0010);
      checkOutput("break stepCount", stepCount, 32'd13);
      checkPulseTrain("pre-break pulse", 0, b0 + 10, 3, 4);
      runCycles(8);
      checkOutput("break no pulses", 32'(pulseLog.size()), 32'd4);
      checkOutput("break held", 32'(state), 32'd2);

      // Resume from BRK: the breakpointed instruction executes once.
      pulseLog.delete();
      r0 = cyc;
      applyStimulus(1'b0, 1'b1, 1'b0);
      runCycles(10);
      checkOutput("resume pulse", 32'(cpuEn), 32'd1);
      checkOutput("resume state", 32'(state), 32'd1);
      runCycles(1);
      checkOutput("resume pc", pc, 32'h0040_0014);
      breakPC = 32'h0040_0020;
      applyStimulus(1'b0, 1'b0, 1'b0);
      runCycles(11);
      checkOutput("second break state", 32'(state), 32'd2);
      checkOutput("second break stepCount", stepCount, 32'd17);
      checkPulseTrain("resume train", 0, r0 + 10, 3, 4);

      // Step out of BRK.
      runCycles(3);
      s0 = cyc;
      applyStimulus(1'b1, 1'b0, 1'b0);
      runCycles(6);
      checkOutput("brk step early", 32'(cpuEn), 32'd0);
      checkOutput("brk step early state", 32'(state), 32'd2);
      runCycles(1);
      checkOutput("brk step pulse", 32'(cpuEn), 32'd1);
      checkOutput("brk step state", 32'(state), 32'd0);
      checkOutput("brk step breakHit", 32'(breakHit), 32'd0);
      checkOutput("brk step count", stepCount, 32'd18);
      runCycles(3);
      applyStimulus(1'b0, 1'b0, 1'b0);
      checkOutput("brk step single", stepCount, 32'd18);
      runCycles(s0 + 20 - cyc);

      // Run and Step pressed together from HALT.
      q0 = cyc;
      pulseLog.delete();
      applyStimulus(1'b1, 1'b1, 1'b0);
      runCycles(7);
      checkOutput("both state", 32'(state), 32'd1);
      checkOutput("both no pulse", 32'(cpuEn), 32'd0);
      checkOutput("both count", stepCount, 32'd18);
      runCycles(3);
      checkOutput("both first run pulse", 32'(cpuEn), 32'd1);
      checkOutput("both run count", stepCount, 32'd19);
      applyStimulus(1'b1, 1'b0, 1'b0);
      runCycles(4);

      // Reset between pulses with Step still held.
      rst = 1'b1;
      tick();
      checkResetOutputs("midrun reset");
      tick();
      checkOutput("reset no pulse", 32'(cpuEn), 32'd0);
      checkOutput("reset log", 32'(pulseLog.size()), 32'd2);
      breakPC = pc;
      rst = 1'b0;
      rr = cyc;
      runCycles(6);
      checkOutput("post-reset early", 32'(cpuEn), 32'd0);
      runCycles(1);
      checkOutput("post-reset step pulse", 32'(cpuEn), 32'd1);
      checkOutput("post-reset count", stepCount, 32'd1);
      checkOutput("post-reset state", 32'(state), 32'd0);
      applyStimulus(1'b0, 1'b0, 1'b0);
      runCycles(10);
      checkOutput("final count", stepCount, 32'd1);
      if (q0 < 0 || rr < 0) testsFailed++;

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule

// File: doc/cpu_run_controller.md
# cpu_run_controller

Synchronous run-control unit for the single-cycle MIPS datapath on the DE2-70 board. It replaces free-toggling derived clocks with clean one-cycle enable pulses on the single 50 MHz clock: manual single-step, continuous run at slow or fast rate, and a PC breakpoint. It also generates the memory-side enable, debounces the push-buttons, and exposes status for the LEDs and 7-segment displays.

## Interface
- SLOW_DIV, 10000000: clock cycles between instruction enables in slow run (minimum 2)
- FAST_DIV, 31: clock cycles between instruction enables in fast run (minimum 2)
- MEM_DIV, 5: period of the memory enable pulse (minimum 1)
- DEBOUNCE, 500000: consecutive stable cycles required to accept a key level (minimum 1)
- iCLK  in  1  50 MHz board clock; all logic on its rising edge
- iRST  in  1  synchronous, active-high reset
- iKeyStep  in  1  step button, active-high (already inverted), asynchronous
- iKeyRun  in  1  run/halt toggle button, active-high, asynchronous
- iKeySpeed  in  1  slow/fast toggle button, active-high, asynchronous
- iBreakEn  in  1  breakpoint enable (switch, quasi-static)
- iBreakPC  in  32  breakpoint address
- iPC  in  32  current PC from the datapath
- oCPUEn  out  1  one-cycle instruction-advance enable to the datapath
- oMemEn  out  1  one-cycle memory enable, every MEM_DIV cycles
- oState  out  2  00 HALT, 01 RUN, 10 BRK
- oFast  out  1  1 = fast rate selected
- oBreakHit  out  1  high while in BRK
- oStepCount  out  32  number of oCPUEn pulses issued since reset

## Operation
- Key conditioning, per key: 2-flop synchronizer, then debouncer; the accepted level changes only after the synchronized input differs from it for DEBOUNCE consecutive cycles. A press is a one-cycle pulse on the 0->1 transition of the accepted level. Holding a key yields exactly one press.
- Press priority within a cycle: Run > Step; Speed is independent.
- Speed press: toggles oFast in any state; the rate counter clears to 0.
- HALT: Step press -> one oCPUEn pulse; stay in HALT. Run press -> RUN, rate counter cleared.
- RUN: rate counter counts 0..DIV-1 (DIV = FAST_DIV if oFast, else SLOW_DIV) and wraps. At terminal count an issue is attempted. Run press -> HALT; no issue that cycle.
- Issue attempt (RUN terminal count, or Step press in HALT/BRK): if iBreakEn, iPC == iBreakPC, skip flag clear, and source is RUN, the pulse is suppressed and the state becomes BRK. Otherwise oCPUEn pulses and the skip flag clears.
- BRK: Step press -> one oCPUEn pulse, state HALT. Run press -> RUN with skip flag set, so the breakpointed instruction executes once.
- Step presses never trigger the breakpoint.
- oStepCount increments on every oCPUEn pulse, modulo 2^32.
- oMemEn: a free-running counter 0..MEM_DIV-1 pulses at terminal count, independent of state. With MEM_DIV = 1 it is constantly high.

## Timing
- Reset values: oCPUEn 0, oMemEn 0, oState HALT, oFast 0, oBreakHit 0, oStepCount 0, skip 0, all counters 0, debounced levels 0.
- All outputs are registered.
- Key latency: 2 sync cycles + DEBOUNCE cycles to the internal press pulse at cycle t. oCPUEn is high in cycle t+1, and oStepCount updates in the same cycle.
- oCPUEn is never high on two consecutive cycles, because every DIV is at least 2 and presses are separated by a debounce.
- The breakpoint compare uses iPC in the cycle of the issue attempt. The datapath updates iPC only on oCPUEn, so iPC is stable at compare time.
- First RUN issue occurs DIV cycles after entering RUN.
- Reset mid-operation: state returns to HALT immediately on the next edge with no further oCPUEn. A key held through reset registers a press DEBOUNCE+2 cycles after iRST falls.

## Test plan
Parameters for all scenarios: DEBOUNCE=4, SLOW_DIV=8, FAST_DIV=3, MEM_DIV=5.
- Reset then idle 40 cycles -> oCPUEn never high, oMemEn high every 5th cycle, oState 00, oStepCount 0.
- Step held 20 cycles with a 3-cycle glitch beforehand -> glitch ignored, exactly one oCPUEn at 7 cycles after the stable rising input, oStepCount 1.
- Run press, then Speed press after 3 pulses -> oCPUEn period 8 then 3, oFast 1, counter restarted at the toggle, oStepCount counts every pulse.
- RUN fast with iBreakEn=1, iBreakPC=0x00400010, PC model +4 per pulse from 0x00400000 -> 4 pulses, then oState 10, oBreakHit 1, no further pulses. Run press -> immediate execution past 0x00400010, continues.
- In BRK, Step press -> exactly one pulse, oState 00. Run and Step pressed in the same cycle from HALT -> RUN entered, no step pulse.
- Assert iRST during RUN between pulses -> all outputs at reset values on the next edge; with a key held, a press appears 6 cycles after release.
